// File: rtl/rgb_fader_pkg.sv
// rgb_fader_pkg: shared FSM encoding and channel indices for the RGB fader.
// Channel indices follow the colour mixer's bit order {R,G,B}.
package rgb_fader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

endpackage : rgb_fader_pkg

// File: rtl/rgb_fader_chan.sv
// rgb_fader_chan: one PWM-dimmed LED channel.
// Holds the duty register that steps +/-1 toward the target, the shadow
// compare value reloaded once per PWM period, and the active-low pin register.
// Optional macro RGB_FADER_GAMMA_EN: shadow value is gamma(duty) instead of duty.
module rgb_fader_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                period_end,
    input  logic                step_stb,
    input  logic                target_on,
    output logic                led,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic [PWM_BITS-1:0] duty_s;
    logic [PWM_BITS-1:0] shadow_val;
    logic                lit;

    assign target    = target_on ? MAX : '0;
    assign at_target = (duty == target);

    // Step the duty one count toward the target on each step strobe; the
    // comparisons guarantee it never overshoots and never wraps.
    always_comb begin
        // NOTE: default first so every path assigns duty_next and no latch is inferred.
        duty_next = duty;
        if (step_stb) begin
            if (duty < target) begin
                duty_next = duty + 1'b1;
            end else if (duty > target) begin
                duty_next = duty - 1'b1;
            end
        end
    end

`ifdef RGB_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;

    // Square-law brightness curve; full scale is kept exactly full scale.
    always_comb begin
        duty_sq    = {{PWM_BITS{1'b0}}, duty_next} * {{PWM_BITS{1'b0}}, duty_next};
        shadow_val = (duty_next == MAX) ? MAX : duty_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign shadow_val = duty_next;
`endif

    // Compare against the shadow value; full scale is forced on so the pin
    // does not blink off for the one count where pwm_cnt == MAX.
    assign lit = (pwm_cnt < duty_s) || (duty_s == MAX);

    // Duty, shadow and pin registers. The shadow takes duty_next so a step
    // that lands on the period-end edge is already used from pwm_cnt = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty   <= '0;
            duty_s <= '0;
            led    <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            duty <= duty_next;
            if (period_end) begin
                duty_s <= shadow_val;
            end
            led <= ~lit;
        end
    end

endmodule : rgb_fader_chan

// File: rtl/rgb_fader.sv
// rgb_fader: crossfading PWM driver for an active-low RGB LED.
// Registers the 3-bit colour code, runs the shared PWM and fade-step timers,
// and tracks whether any channel is still fading (BUSY).
// Optional macro RGB_FADER_GAMMA_EN: gamma-corrected compare values per channel.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] COLOR,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic       BUSY
);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam int                  STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [2:0]          color_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                period_end;
    logic                step_stb;
    logic [2:0]          at_target;
    logic                all_at_target;
    state_t              state;
    state_t              state_next;

    assign period_end    = (pwm_cnt == MAX);
    assign step_stb      = period_end && (step_cnt == STEP_LAST);
    assign all_at_target = &at_target;
    assign BUSY          = (state == FADE);

    // Colour input register and the free-running PWM / fade-step timers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            color_q  <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            color_q <= COLOR;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: fade while any channel is away from its target.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!all_at_target) state_next = FADE;
            FADE:    if (all_at_target)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    rgb_fader_chan #(.PWM_BITS(PWM_BITS)) u_chan_r (
        .clk        (CLK),
        .rst_n      (RST_N),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end),
        .step_stb   (step_stb),
        .target_on  (color_q[CH_R]),
        .led        (LED_R),
        .at_target  (at_target[CH_R])
    );

    rgb_fader_chan #(.PWM_BITS(PWM_BITS)) u_chan_g (
        .clk        (CLK),
        .rst_n      (RST_N),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end),
        .step_stb   (step_stb),
        .target_on  (color_q[CH_G]),
        .led        (LED_G),
        .at_target  (at_target[CH_G])
    );

    rgb_fader_chan #(.PWM_BITS(PWM_BITS)) u_chan_b (
        .clk        (CLK),
        .rst_n      (RST_N),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end),
        .step_stb   (step_stb),
        .target_on  (color_q[CH_B]),
        .led        (LED_B),
        .at_target  (at_target[CH_B])
    );

endmodule : rgb_fader
